ws2812b_rx: RTL
===============

Name: ws2812b_rx

Overview:
- Receive-side counterpart of the on-chip WS2812B strip driver.
- Decodes the single-wire NRZ WS2812B waveform into 24-bit GRB pixel words, with the first wire bit landing in bit 23.
- Detects the low-time latch (reset) condition and reports decode errors.
- Used as a loopback checker and as a chain-input peripheral on the TinyQV peripheral bus; the clock is nominally 64 MHz.

Parameters:
- T_THRESH, 38: high-time threshold in clk cycles; a high pulse of length >= T_THRESH decodes as 1, otherwise 0 (about 0.6 us).
- T_MIN_HIGH, 8: a high pulse shorter than this is a glitch, produces no bit, and sets err.
- T_HIGH_MAX, 96: a high pulse longer than this is a stuck line; enter ERROR.
- T_LATCH, 3200: consecutive low cycles that constitute a latch (50 us).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- din  in  1  raw serial line; synchronized internally
- pixel  out  24  last decoded word {G,R,B}
- pixel_valid  out  1  pixel holds an unconsumed word
- pixel_ready  in  1  consumer accepts pixel when pixel_valid & pixel_ready
- latch  out  1  one-cycle pulse on latch detection
- pix_count  out  8  pixels completed since last latch; saturates at 255
- overrun  out  1  sticky: a word completed while pixel_valid was already high
- err  out  1  sticky: glitch, stuck-high, or partial word at latch
- clr_status  in  1  clears overrun and err; the set condition wins if simultaneous
- dout  out  1  forwarded line (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: pixel=0, pixel_valid=0, latch=0, pix_count=0, overrun=0, err=0, dout=0.
  - Internal state: state=LOW, bit_cnt=0, cnt=0, synchronizer flops=0.
  - Reset mid-frame discards any partial word.
- Input synchronization: din passes through a 2-flop synchronizer (ds). Edges are detected on ds against its previous value. All timing below is in ds domain (+2 cycles from pin).
- Width counter: cnt, width clog2(T_LATCH+1), cleared on every ds edge, saturating.
- State LOW (ds=0):
  - cnt increments each cycle.
  - When cnt reaches T_LATCH-1, latch pulses for exactly one cycle. The pulse occurs once per low period and does not repeat while the line stays low.
  - On the latch cycle: if bit_cnt!=0, set err and discard the partial word. Then bit_cnt=0 and pix_count=0.
  - Rising edge on ds -> HIGH with cnt=0.
- State HIGH (ds=1):
  - cnt increments each cycle.
  - If cnt reaches T_HIGH_MAX -> ERROR and set err.
  - Falling edge on ds with width w=cnt+1:
    - w < T_MIN_HIGH: set err, no bit.
    - Otherwise shift in (w >= T_THRESH), MSB first, and increment bit_cnt.
    - In all cases go to LOW with cnt=0.
- State ERROR:
  - Discard the partial word and set bit_cnt=0.
  - Wait for a falling edge on ds, then go to LOW with cnt=0.
  - A subsequent latch is still detected normally.
- Word completion:
  - On the falling edge that delivers bit 24, bit_cnt wraps to 0.
  - The next cycle shows pixel=word, pixel_valid=1, and pix_count incremented (saturating).
  - If pixel_valid=1 and pixel_ready=0 at completion, the new word is dropped, the old word is kept, overrun is set, and pix_count still increments.
  - If pixel_ready=1 in the same cycle as completion, the word is accepted and replaced without overrun.
- Handshake: pixel_valid falls the cycle after pixel_valid & pixel_ready. pixel is stable while pixel_valid=1.
- Low-period length between bits is not checked; only T_LATCH matters.

Optional Feature:
- Macro: WS2812B_RX_FWD_EN.
- Defined (chip-emulation mode):
  - Only the first word after each latch (pix_count==0 at completion) is presented on pixel/pixel_valid.
  - Once that word completes, dout = ds, delayed one cycle, until the next latch. All later words are forwarded, not decoded, and cannot cause overrun.
  - dout=0 before the first word completes and during latch.
- Not defined: dout is tied to 0 and every word is presented.

Test Plan:
- Send 0xFF0000 (24 bits: highs of 51 cycles for 1, 26 for 0, period 80), then 3300 low, pixel_ready=1 -> pixel=0xFF0000, pixel_valid one cycle, latch pulses once, pix_count 1 then 0 after latch, err=0.
- Send two words 0x123456 and 0xABCDEF with pixel_ready=0 -> pixel=0x123456, overrun=1, pix_count=2; pulse clr_status -> overrun=0.
- Send 10 bits, then 3300 low -> latch pulse, err=1, pixel_valid=0, bit_cnt restarts; next word 0x00A5A5 decodes correctly.
- High pulse of 5 cycles mid-word -> err=1, bit count unchanged. High of 120 cycles -> ERROR, partial discarded, following full word decodes.
- Boundary widths: high of 37 -> 0, high of 38 -> 1; low of 3199 -> no latch, low of 3200 -> latch.
- With WS2812B_RX_FWD_EN: send 0x010203, 0x040506, latch -> pixel=0x010203 only; dout reproduces the 0x040506 waveform delayed 3 cycles from din; no overrun.

Source files
------------

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: decodes NRZ high-time bits into 24-bit GRB words.
// Optional macro WS2812B_RX_FWD_EN: present only the first word per frame and forward the rest on dout.
module ws2812b_rx #(
  parameter int T_THRESH   = 38,
  parameter int T_MIN_HIGH = 8,
  parameter int T_HIGH_MAX = 96,
  parameter int T_LATCH    = 3200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        latch,
  output logic [7:0]  pix_count,
  output logic        overrun,
  output logic        err,
  input  logic        clr_status,
  output logic        dout
);
  localparam int CW = $clog2(T_LATCH + 1);

  typedef enum logic [1:0] {ST_LOW, ST_HIGH, ST_ERROR} state_t;

  state_t          state;
  logic            ds_meta, ds, ds_q;
  logic [CW-1:0]   cnt;
  logic [4:0]      bit_cnt;
  logic [22:0]     sh;
  logic            rise, fall, bit_val, latch_det, present;
  logic [CW-1:0]   w;

  assign rise      = ds & ~ds_q;
  assign fall      = ~ds & ds_q;
  assign w         = cnt + CW'(1);
  assign bit_val   = (w >= CW'(T_THRESH));
  assign latch_det = (state == ST_LOW) && (cnt == CW'(T_LATCH - 1));

`ifdef WS2812B_RX_FWD_EN
  logic fwd;
  assign present = ~fwd;
`else
  assign present = 1'b1;
  assign dout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_meta     <= 1'b0;
      ds          <= 1'b0;
      ds_q        <= 1'b0;
      state       <= ST_LOW;
      cnt         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      latch       <= 1'b0;
      pix_count   <= '0;
      overrun     <= 1'b0;
      err         <= 1'b0;
`ifdef WS2812B_RX_FWD_EN
      fwd         <= 1'b0;
      dout        <= 1'b0;
`endif
    end else begin
      ds_meta <= din;
      ds      <= ds_meta;
      ds_q    <= ds;
      latch   <= 1'b0;

      if (rise || fall)
        cnt <= '0;
      else if (cnt != CW'(T_LATCH))
        cnt <= cnt + CW'(1);

      // clear first so a same-cycle set below wins
      if (clr_status) begin
        overrun <= 1'b0;
        err     <= 1'b0;
      end

      if (pixel_valid && pixel_ready)
        pixel_valid <= 1'b0;

`ifdef WS2812B_RX_FWD_EN
      dout <= (fwd && !latch_det) ? ds : 1'b0;
`endif

      case (state)
        ST_LOW: begin
          if (latch_det) begin
            latch     <= 1'b1;
            if (bit_cnt != 5'd0)
              err <= 1'b1;
            bit_cnt   <= '0;
            pix_count <= '0;
`ifdef WS2812B_RX_FWD_EN
            fwd       <= 1'b0;
`endif
          end
          if (rise)
            state <= ST_HIGH;
        end
        ST_HIGH: begin
          if (cnt == CW'(T_HIGH_MAX)) begin
            // stuck high: a falling edge in this same cycle must not be lost
            err     <= 1'b1;
            bit_cnt <= '0;
            state   <= fall ? ST_LOW : ST_ERROR;
          end else if (fall) begin
            state <= ST_LOW;
            if (w < CW'(T_MIN_HIGH)) begin
              err <= 1'b1;
            end else begin
              sh <= {sh[21:0], bit_val};
              if (bit_cnt == 5'd23) begin
                bit_cnt <= '0;
                if (pix_count != 8'hFF)
                  pix_count <= pix_count + 8'd1;
                if (present) begin
                  if (!pixel_valid || pixel_ready) begin
                    pixel       <= {sh, bit_val};
                    pixel_valid <= 1'b1;
                  end else begin
                    overrun <= 1'b1;
                  end
                end
`ifdef WS2812B_RX_FWD_EN
                fwd <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
        end
        ST_ERROR: begin
          bit_cnt <= '0;
          if (fall)
            state <= ST_LOW;
        end
        default: state <= ST_LOW;
      endcase
    end
  end
endmodule
